// File: rtl/system_onchip_mem_ctrl.sv
// On-chip single-port RAM Avalon-MM slave with a READ_LATENCY-deep read pipeline.
// Define ONCHIP_MEM_BURST_EN to compile in linear read/write bursts.
module system_onchip_mem_ctrl #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 15,
   parameter int unsigned DEPTH        = 20480,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned BURST_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clken,
   input  logic                    reset_req,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic [DATA_WIDTH-1:0]   writedata,
   input  logic [BURST_WIDTH-1:0]  burstcount,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest,
   output logic                    addr_error
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                  en;
   logic                  cmd_acc;
   logic                  rd_issue;
   logic                  wr_issue;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic                  in_range;
   logic [IdxWidth-1:0]   idx;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [READ_LATENCY-1:0] pvalid_q;
   logic [DATA_WIDTH-1:0]   pdata_q [READ_LATENCY];

   assign en      = clken & ~reset_req;
   assign cmd_acc = chipselect & (read | write) & ~waitrequest & en;

`ifdef ONCHIP_MEM_BURST_EN
   typedef enum logic [1:0] {StIdle, StRBurst, StWBurst} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  baddr_q, baddr_d;
   logic [BURST_WIDTH-1:0] beats_q, beats_d;
   logic                   go;

   assign go          = en & ~reset;
   assign waitrequest = reset | ~en | (state_q == StRBurst);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         baddr_q <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         baddr_q <= baddr_d;
         beats_q <= beats_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      baddr_d    = baddr_q;
      beats_d    = beats_q;
      rd_issue   = 1'b0;
      wr_issue   = 1'b0;
      issue_addr = address;
      unique case (state_q)
         StIdle: begin
            if (cmd_acc) begin
               if (write) begin
                  wr_issue = 1'b1;
                  if (burstcount > BURST_WIDTH'(1)) begin
                     state_d = StWBurst;
                     baddr_d = address + ADDR_WIDTH'(1);
                     beats_d = burstcount - BURST_WIDTH'(1);
                  end
               end else if (burstcount > BURST_WIDTH'(1)) begin
                  // Burst reads issue every beat (including the first) from RBURST.
                  state_d = StRBurst;
                  baddr_d = address;
                  beats_d = burstcount;
               end else begin
                  rd_issue = 1'b1;
               end
            end
         end
         StRBurst: begin
            if (go) begin
               rd_issue   = 1'b1;
               issue_addr = baddr_q;
               baddr_d    = baddr_q + ADDR_WIDTH'(1);
               beats_d    = beats_q - BURST_WIDTH'(1);
               if (beats_q == BURST_WIDTH'(1)) state_d = StIdle;
            end
         end
         StWBurst: begin
            if (go && chipselect && write) begin
               wr_issue   = 1'b1;
               issue_addr = baddr_q;
               baddr_d    = baddr_q + ADDR_WIDTH'(1);
               beats_d    = beats_q - BURST_WIDTH'(1);
               if (beats_q == BURST_WIDTH'(1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end
`else
   logic unused_burstcount;

   assign unused_burstcount = ^burstcount;
   assign waitrequest       = reset | ~en;
   assign wr_issue          = cmd_acc & write;
   assign rd_issue          = cmd_acc & ~write;
   assign issue_addr        = address;
`endif

   assign in_range   = 32'(issue_addr) < DEPTH;
   assign idx        = issue_addr[IdxWidth-1:0];
   assign addr_error = (rd_issue | wr_issue) & ~in_range;
   // Out-of-range reads still occupy a pipeline slot, returning zero.
   assign rd_word    = (rd_issue && in_range) ? mem[idx] : '0;

   // Memory has no reset so contents survive a bus reset.
   always_ff @(posedge clk) begin
      if (wr_issue && in_range) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pvalid_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pdata_q[i] <= '0;
      end else if (en) begin
         pvalid_q[0] <= rd_issue;
         pdata_q[0]  <= rd_word;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pvalid_q[i] <= pvalid_q[i-1];
            pdata_q[i]  <= pdata_q[i-1];
         end
      end
   end

   assign readdata      = pdata_q[READ_LATENCY-1];
   assign readdatavalid = pvalid_q[READ_LATENCY-1] & en & ~reset;

endmodule

// File: tb/tb_system_onchip_mem_ctrl.sv
// Directed self-checking bench for system_onchip_mem_ctrl (default parameters).
module tb_system_onchip_mem_ctrl;

   localparam int DW = 32;
   localparam int AW = 15;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          reset, clken, reset_req, chipselect, read, write;
   logic [AW-1:0] address;
   logic [DW/8-1:0] byteenable;
   logic [DW-1:0] writedata, readdata;
   logic [BW-1:0] burstcount;
   logic          readdatavalid, waitrequest, addr_error;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   system_onchip_mem_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .clken         (clken),
      .reset_req     (reset_req),
      .chipselect    (chipselect),
      .read          (read),
      .write         (write),
      .address       (address),
      .byteenable    (byteenable),
      .writedata     (writedata),
      .burstcount    (burstcount),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .waitrequest   (waitrequest),
      .addr_error    (addr_error)
   );

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      address    = '0;
      writedata  = '0;
      byteenable = '0;
      burstcount = BW'(1);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      tick();
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
      tick();
      idle();
   endtask

   // Single read; returns accept-cycle addr_error, valid one cycle later, valid/data two later.
   task automatic rd(input logic [AW-1:0] a, output logic err, output logic early,
                     output logic vld, output logic [DW-1:0] d);
      tick();
      chipselect = 1'b1; read = 1'b1; address = a;
      #1 err = addr_error;
      tick();
      idle();
      #1 early = readdatavalid;
      tick();
      vld = readdatavalid;
      d   = readdata;
   endtask

   task automatic test_reset();
      reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
      idle();
      repeat (3) tick();
      vectors++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait: got %b want 1", waitrequest); end
      vectors++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b want 0", readdatavalid); end
      vectors++; if (readdata !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", readdata); end
      chipselect = 1'b1; read = 1'b1; address = AW'(20480);
      #1;
      vectors++; if (addr_error !== 1'b0) begin errors++; $display("FAIL rst_aerr: got %b want 0", addr_error); end
      idle();
      tick();
      reset = 1'b0;
      #1;
      vectors++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL rst_release_wait: got %b want 0", waitrequest); end
      reset_req = 1'b1;
      #1;
      vectors++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL reset_req_wait: got %b want 1", waitrequest); end
      reset_req = 1'b0;
   endtask

   task automatic test_byteenable();
      wr(AW'(5), 32'h1122_3344, 4'hF);
      tick();
      chipselect = 1'b1; write = 1'b1; address = AW'(5); writedata = 32'hDEAD_BEEF; byteenable = 4'b0101;
      tick();
      // Read on the cycle right after the write must see the merged word.
      idle();
      chipselect = 1'b1; read = 1'b1; address = AW'(5);
      #1;
      vectors++; if (addr_error !== 1'b0) begin errors++; $display("FAIL be_aerr: got %b want 0", addr_error); end
      tick();
      idle();
      #1;
      vectors++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL be_lat1: got %b want 0", readdatavalid); end
      tick();
      vectors++; if (readdatavalid !== 1'b1) begin errors++; $display("FAIL be_lat2: got %b want 1", readdatavalid); end
      vectors++; if (readdata !== 32'h11AD_33EF) begin errors++; $display("FAIL be_data: got %h want 11ad33ef", readdata); end
      tick();
      vectors++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL be_lat3: got %b want 0", readdatavalid); end
   endtask

   task automatic test_back_to_back();
      bit exp_v [14] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
      int exp_i [14] = '{0, 0, 0, 1, 0, 0, 0, 2, 3, 4, 5, 6, 7, 0};
      for (int i = 0; i < 8; i++) wr(AW'(i), 32'hA000_0000 | i, 4'hF);
      for (int c = 0; c < 14; c++) begin
         tick();
         clken = !(c >= 4 && c <= 6);
         if (c <= 10) begin
            chipselect = 1'b1; read = 1'b1;
            address = (c < 4) ? AW'(c) : ((c <= 7) ? AW'(4) : AW'(c - 3));
         end else begin
            idle();
         end
         #1;
         vectors++;
         if (waitrequest !== (c >= 4 && c <= 6)) begin
            errors++; $display("FAIL b2b_wait c%0d: got %b", c, waitrequest);
         end
         vectors++;
         if (readdatavalid !== exp_v[c]) begin
            errors++; $display("FAIL b2b_rdv c%0d: got %b want %b", c, readdatavalid, exp_v[c]);
         end
         if (exp_v[c]) begin
            vectors++;
            if (readdata !== (32'hA000_0000 | exp_i[c])) begin
               errors++; $display("FAIL b2b_data c%0d: got %h want %h", c, readdata, 32'hA000_0000 | exp_i[c]);
            end
         end
      end
      clken = 1'b1;
      idle();
   endtask

   task automatic test_out_of_range();
      logic e, early, v;
      logic [DW-1:0] d;
      wr(AW'(20479), 32'hCAFE_F00D, 4'hF);
      wr(AW'(4096), 32'h1234_5678, 4'hF);
      rd(AW'(20479), e, early, v, d);
      vectors++; if (e !== 1'b0) begin errors++; $display("FAIL top_aerr: got %b want 0", e); end
      vectors++; if (v !== 1'b1 || d !== 32'hCAFE_F00D) begin errors++; $display("FAIL top_data: got %b/%h want 1/cafef00d", v, d); end
      rd(AW'(20480), e, early, v, d);
      vectors++; if (e !== 1'b1) begin errors++; $display("FAIL oor_aerr: got %b want 1", e); end
      vectors++; if (early !== 1'b0) begin errors++; $display("FAIL oor_early: got %b want 0", early); end
      vectors++; if (v !== 1'b1 || d !== '0) begin errors++; $display("FAIL oor_data: got %b/%h want 1/0", v, d); end
      tick();
      chipselect = 1'b1; write = 1'b1; address = AW'(20480); writedata = '1; byteenable = 4'hF;
      #1;
      vectors++; if (addr_error !== 1'b1) begin errors++; $display("FAIL oorw_aerr: got %b want 1", addr_error); end
      tick();
      idle();
      #1;
      vectors++; if (addr_error !== 1'b0) begin errors++; $display("FAIL oorw_pulse: got %b want 0", addr_error); end
      rd(AW'(20479), e, early, v, d);
      vectors++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL oorw_top: got %h want cafef00d", d); end
      rd(AW'(4096), e, early, v, d);
      vectors++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL oorw_alias: got %h want 12345678", d); end
      rd(AW'(0), e, early, v, d);
      vectors++; if (d !== 32'hA000_0000) begin errors++; $display("FAIL oorw_zero: got %h want a0000000", d); end
   endtask

`ifdef ONCHIP_MEM_BURST_EN
   task automatic test_read_burst();
      for (int i = 0; i < 4; i++) wr(AW'(100 + i), 32'hB000_0000 + 100 + i, 4'hF);
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c == 0) begin
            chipselect = 1'b1; read = 1'b1; address = AW'(100); burstcount = BW'(4);
         end else begin
            idle();
         end
         #1;
         vectors++;
         if (waitrequest !== (c >= 1 && c <= 4)) begin
            errors++; $display("FAIL rb_wait c%0d: got %b", c, waitrequest);
         end
         vectors++;
         if (readdatavalid !== (c >= 3 && c <= 6)) begin
            errors++; $display("FAIL rb_rdv c%0d: got %b", c, readdatavalid);
         end
         if (c >= 3 && c <= 6) begin
            vectors++;
            if (readdata !== 32'hB000_0000 + 100 + c - 3) begin
               errors++; $display("FAIL rb_data c%0d: got %h want %h", c, readdata, 32'hB000_0000 + 100 + c - 3);
            end
         end
      end
   endtask

   task automatic test_write_burst();
      logic e, early, v;
      logic [DW-1:0] d;
      for (int c = 0; c < 4; c++) begin
         tick();
         chipselect = 1'b1; write = 1'b1; byteenable = 4'hF; burstcount = BW'(4);
         address = (c == 0) ? AW'(200) : AW'(0);
         writedata = 32'hC000_0000 + c;
         #1;
         vectors++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL wb_wait c%0d: got %b", c, waitrequest); end
      end
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         rd(AW'(200 + i), e, early, v, d);
         vectors++;
         if (v !== 1'b1 || d !== 32'hC000_0000 + i) begin
            errors++; $display("FAIL wb_data%0d: got %b/%h want 1/%h", i, v, d, 32'hC000_0000 + i);
         end
      end
      rd(AW'(0), e, early, v, d);
      vectors++; if (d !== 32'hA000_0000) begin errors++; $display("FAIL wb_addr0: got %h want a0000000", d); end
   endtask

   task automatic test_reset_mid_burst();
      logic e, early, v;
      logic [DW-1:0] d;
      for (int c = 0; c < 10; c++) begin
         tick();
         reset = (c == 3);
         if (c == 0) begin
            chipselect = 1'b1; read = 1'b1; address = AW'(0); burstcount = BW'(8);
         end else begin
            idle();
         end
         #1;
         vectors++;
         if (waitrequest !== (c >= 1 && c <= 3)) begin
            errors++; $display("FAIL rmb_wait c%0d: got %b", c, waitrequest);
         end
         vectors++;
         if (readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rmb_rdv c%0d: got %b want 0", c, readdatavalid);
         end
      end
      for (int i = 0; i < 8; i += 3) begin
         rd(AW'(i), e, early, v, d);
         vectors++;
         if (v !== 1'b1 || d !== (32'hA000_0000 | i)) begin
            errors++; $display("FAIL rmb_mem%0d: got %b/%h want 1/%h", i, v, d, 32'hA000_0000 | i);
         end
      end
   endtask
`else
   task automatic test_burst_ignored();
      for (int c = 0; c < 5; c++) begin
         tick();
         if (c == 0) begin
            chipselect = 1'b1; read = 1'b1; address = AW'(1); burstcount = BW'(4);
         end else begin
            idle();
         end
         #1;
         vectors++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL nb_wait c%0d: got %b", c, waitrequest); end
         vectors++;
         if (readdatavalid !== (c == 2)) begin
            errors++; $display("FAIL nb_rdv c%0d: got %b", c, readdatavalid);
         end
         if (c == 2) begin
            vectors++;
            if (readdata !== 32'hA000_0001) begin errors++; $display("FAIL nb_data: got %h want a0000001", readdata); end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_byteenable();
      test_back_to_back();
      test_out_of_range();
`ifdef ONCHIP_MEM_BURST_EN
      test_read_burst();
      test_write_burst();
      test_reset_mid_burst();
`else
      test_burst_ignored();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
